bcd_to_binary: RTL and testbench
================================

BCD_TO_BINARY -- requirements
Module: bcd_to_binary

Interface
REQ-001 Parameter N_DIGITS, default 2, SHALL be the number of packed BCD input digits.
REQ-002 Parameter OUTPUT_LENGTH, default 8, SHALL be the binary result width and SHALL satisfy 2^OUTPUT_LENGTH >= 10^N_DIGITS.
REQ-003 clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL request a conversion of the value on bcd.
REQ-006 bcd  input  N_DIGITS*4  SHALL carry packed BCD, digit 0 in bits [3:0].
REQ-007 binary  output  OUTPUT_LENGTH  SHALL present the registered result of the last completed conversion.
REQ-008 completed  output  1  SHALL pulse high for one cycle when binary is updated.
REQ-009 busy  output  1  SHALL be high while a conversion is in progress.
REQ-010 digit_error  output  1  SHALL flag any input digit above 9, valid with completed.

Function
REQ-011 The FSM SHALL have states IDLE, CONVERT and DONE.
REQ-012 In IDLE or DONE, start high at a rising edge SHALL capture bcd into a working register, clear the shift counter and enter CONVERT.
REQ-013 In IDLE or DONE with start low, the FSM SHALL go to (or stay in) IDLE.
REQ-014 Each CONVERT cycle SHALL shift {working BCD, partial binary} right by one bit, then subtract 3 from every BCD digit whose value is >= 8 (reverse double-dabble).
REQ-015 After exactly OUTPUT_LENGTH CONVERT cycles the FSM SHALL load binary from the partial result and enter DONE.
REQ-016 completed SHALL be high exactly in the DONE cycle, OUTPUT_LENGTH cycles after the start edge (8 cycles at defaults).
REQ-017 busy SHALL be high exactly in CONVERT.
REQ-018 start while in CONVERT SHALL be ignored with no queuing, and bcd changes after capture SHALL not affect the result.
REQ-019 binary SHALL hold its value between completions and SHALL change only at the edge entering DONE.
REQ-020 Arithmetic SHALL be unsigned, with no overflow possible under REQ-002.

Reset
REQ-021 reset_n low SHALL immediately force IDLE, binary = 0, completed = 0, busy = 0, digit_error = 0 and clear the working registers and counter.
REQ-022 Reset during CONVERT SHALL abort the conversion with no completed pulse, and the first start after release SHALL convert normally.

Configuration
REQ-023 With macro BCD_TO_BINARY_DIGIT_CHECK_EN defined, the captured digits SHALL be checked at capture and digit_error SHALL be set with completed if any digit > 9, with binary still loaded per REQ-014/015.
REQ-024 Without BCD_TO_BINARY_DIGIT_CHECK_EN, digit_error SHALL be tied 0 and no check logic SHALL be built.

Structure
REQ-025 A shared package scoreboard_pkg SHALL hold the FSM state typedef and the BCD digit width constant (4).
REQ-026 A sub-module bcd_digit_adjust (4-bit in, 4-bit out: value >= 8 ? value - 3 : value) SHALL be instantiated once per digit by generate.

Verification
REQ-027 bcd = 0x42, start one cycle -> after 8 cycles completed = 1 for one cycle, binary = 0x2A, digit_error = 0.
REQ-028 bcd = 0x99 -> binary = 0x63; then bcd = 0x00 -> binary = 0x00, with the previous value held until the new completed.
REQ-029 start at 0x17, then start at 0x55 on cycle 3 of CONVERT -> a single completed with binary = 0x11, and the second start is ignored.
REQ-030 reset_n low on cycle 4 of converting 0x63 -> all outputs 0 and no completed pulse; after release, convert 0x05 -> binary = 0x05.
REQ-031 With BCD_TO_BINARY_DIGIT_CHECK_EN, bcd = 0x4A -> digit_error = 1 with completed. Without the macro, digit_error stays 0.
REQ-032 Back-to-back: start held high through DONE -> a new capture in the DONE cycle, with completed pulses exactly OUTPUT_LENGTH+1 cycles apart.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// Shared definitions for the BCD-to-binary converter.
//
// Contents:
//   BCD_DIGIT_W   - width of one packed BCD digit (4)
//   state_e       - converter FSM state encoding
//   digit_invalid - true when a 4-bit BCD digit holds a value above 9
package scoreboard_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] digit);
        return digit > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-digit correction step of the reverse double-dabble algorithm.
// After a right shift, a digit that reads 8 or more has received a bit
// worth 10 from the digit above it; subtracting 3 restores the correct
// BCD value (16/2 = 8 shifted in, 10/2 = 5 wanted, 8 - 5 = 3).
//
// Ports:
//   digit_i - shifted BCD digit
//   digit_o - corrected BCD digit
module bcd_digit_adjust
    import scoreboard_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= 4'd8) ? (digit_i - 4'd3) : digit_i;

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to unsigned binary converter (reverse double-dabble).
// A conversion takes OUTPUT_LENGTH cycles in CONVERT, one bit per cycle,
// followed by a single DONE cycle in which completed is high.
//
// State table:
//   IDLE    | waiting for start
//   CONVERT | shifting/adjusting, one result bit per cycle (busy high)
//   DONE    | result just loaded into binary (completed high for one cycle)
//
// Ports:
//   clock       - single clock, rising edge
//   reset_n     - asynchronous active-low reset
//   start       - request conversion of bcd (ignored while converting)
//   bcd         - packed BCD input, digit 0 in bits [3:0]
//   binary      - registered result of the last completed conversion
//   completed   - one-cycle pulse when binary is updated
//   busy        - high while a conversion is in progress
//   digit_error - an input digit was above 9, valid with completed
//
// Build option:
//   BCD_TO_BINARY_DIGIT_CHECK_EN - when defined, captured digits are checked
//   and digit_error reports invalid input; otherwise digit_error is tied 0.
module bcd_to_binary
    import scoreboard_pkg::*;
#(
    parameter int N_DIGITS      = 2,
    parameter int OUTPUT_LENGTH = 8
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic [N_DIGITS*BCD_DIGIT_W-1:0] bcd,
    output logic [OUTPUT_LENGTH-1:0]        binary,
    output logic                            completed,
    output logic                            busy,
    output logic                            digit_error
);

    localparam int BCD_W = N_DIGITS * BCD_DIGIT_W;
    localparam int CNT_W = $clog2(OUTPUT_LENGTH + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(OUTPUT_LENGTH - 1);

    state_e                   state_q, state_d;
    logic [BCD_W-1:0]         work_q, work_d;
    logic [OUTPUT_LENGTH-1:0] part_q, part_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [OUTPUT_LENGTH-1:0] binary_q, binary_d;

    logic [BCD_W+OUTPUT_LENGTH-1:0] shift_w;
    logic [BCD_W-1:0]               work_shift;
    logic [BCD_W-1:0]               work_adj;
    logic [OUTPUT_LENGTH-1:0]       part_shift;
    logic                           capture;
    logic                           finish;

    // The working BCD and the partial binary shift as one long register;
    // bits leaving the bottom of the BCD field enter the top of the result.
    assign shift_w    = {work_q, part_q} >> 1;
    assign work_shift = shift_w[BCD_W+OUTPUT_LENGTH-1:OUTPUT_LENGTH];
    assign part_shift = shift_w[OUTPUT_LENGTH-1:0];

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (work_shift[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (work_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign capture = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign finish  = (state_q == ST_CONVERT) && (cnt_q == LAST_SHIFT);

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        part_d   = part_q;
        cnt_d    = cnt_q;
        binary_d = binary_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (capture) begin
                    work_d  = bcd;
                    part_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_CONVERT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CONVERT: begin
                work_d = work_adj;
                part_d = part_shift;
                cnt_d  = cnt_q + CNT_W'(1);
                if (finish) begin
                    // Load from the freshly shifted value so the result is
                    // ready exactly OUTPUT_LENGTH edges after capture.
                    binary_d = part_shift;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            part_q   <= '0;
            cnt_q    <= '0;
            binary_q <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            part_q   <= part_d;
            cnt_q    <= cnt_d;
            binary_q <= binary_d;
        end
    end

    assign binary    = binary_q;
    assign busy      = (state_q == ST_CONVERT);
    assign completed = (state_q == ST_DONE);

`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
    logic bad_any;
    logic bad_q, bad_d;
    logic derr_q, derr_d;

    always_comb begin
        bad_any = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (digit_invalid(bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
                bad_any = 1'b1;
            end
        end
    end

    // The flag is taken at capture and only published on entry to DONE,
    // so it lines up with completed and ignores later bcd changes.
    always_comb begin
        bad_d  = bad_q;
        derr_d = 1'b0;
        if (capture) begin
            bad_d = bad_any;
        end
        if (finish) begin
            derr_d = bad_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bad_q  <= 1'b0;
            derr_q <= 1'b0;
        end else begin
            bad_q  <= bad_d;
            derr_q <= derr_d;
        end
    end

    assign digit_error = derr_q;
`else
    assign digit_error = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_binary.sv
module tb_bcd_to_binary;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] bcd = 8'h00;
    logic [7:0] binary;
    logic       completed;
    logic       busy;
    logic       digit_error;

    typedef struct {
        logic [7:0] bin;
        logic       de;
        logic       chk_bin;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
    localparam logic DE_4A = 1'b1;
`else
    localparam logic DE_4A = 1'b0;
`endif

    bcd_to_binary #(.N_DIGITS(2), .OUTPUT_LENGTH(8)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .bcd         (bcd),
        .binary      (binary),
        .completed   (completed),
        .busy        (busy),
        .digit_error (digit_error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every completed pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset_n && completed) begin
            if (sb.size() == 0) begin
                check("unexpected_completed", 0, 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk_bin) check("binary", int'(binary), int'(e.bin));
                check("digit_error", int'(digit_error), int'(e.de));
                check("completed_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic start_conv(input logic [7:0] v, input logic [7:0] exp_bin,
                              input logic exp_de, input logic chk, input logic push);
        @(negedge clock);
        if (push) sb.push_back('{exp_bin, exp_de, chk, cyc + 9});
        bcd   = v;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        bcd   = ~v;
        check("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check(name, sb.size(), 0);
        repeat (2) @(negedge clock);
        check("busy_idle", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        #12;
        check("rst_binary", int'(binary), 0);
        check("rst_completed", int'(completed), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_digit_error", int'(digit_error), 0);
        @(negedge clock);
        reset_n = 1'b1;

        start_conv(8'h42, 8'h2A, 1'b0, 1'b1, 1'b1);
        wait_drain("drain_42");

        start_conv(8'h99, 8'h63, 1'b0, 1'b1, 1'b1);
        wait_drain("drain_99");
        start_conv(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clock);
        check("hold_prev_binary", int'(binary), 8'h63);
        wait_drain("drain_00");

        start_conv(8'h17, 8'h11, 1'b0, 1'b1, 1'b1);
        @(negedge clock);
        bcd   = 8'h55;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_drain("drain_17");
        repeat (12) @(negedge clock);
        check("binary_after_ignored_start", int'(binary), 8'h11);

        start_conv(8'h10, 8'h0A, 1'b0, 1'b1, 1'b1);
        wait_drain("drain_10");

        start_conv(8'h4A, 8'h00, DE_4A, 1'b0, 1'b1);
        wait_drain("drain_4A");

        // Back-to-back: start held through DONE recaptures immediately.
        @(negedge clock);
        c = cyc;
        sb.push_back('{8'h2A, 1'b0, 1'b1, c + 9});
        bcd   = 8'h42;
        start = 1'b1;
        repeat (9) @(negedge clock);
        check("b2b_first_done", int'(completed), 1);
        bcd = 8'h13;
        sb.push_back('{8'h0D, 1'b0, 1'b1, cyc + 9});
        @(negedge clock);
        start = 1'b0;
        check("b2b_busy_again", int'(busy), 1);
        wait_drain("drain_b2b");

        // Reset during conversion aborts with no completed pulse.
        start_conv(8'h63, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("abort_binary", int'(binary), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_completed", int'(completed), 0);
        check("abort_digit_error", int'(digit_error), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (12) @(negedge clock);
        check("abort_binary_after", int'(binary), 0);
        start_conv(8'h05, 8'h05, 1'b0, 1'b1, 1'b1);
        wait_drain("drain_05");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
